// File: rtl/comp_seq.sv
// Sequential magnitude comparator: walks the operands MSB-first, DIGIT bits per clock, and stops at the first unequal slice.
// Optional feature macro SIGNED_CMP_EN adds the signed_mode input for two's-complement comparison.
module comp_seq #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
`ifdef SIGNED_CMP_EN
    input  logic             signed_mode,
`endif
    output logic             busy,
    output logic             done,
    output logic             less,
    output logic             greater,
    output logic             eq
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        CMP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    logic             r_less;
    logic             r_greater;
    logic             r_eq;
    logic             w_signed;
    logic [DIGIT-1:0] w_sa;
    logic [DIGIT-1:0] w_sb;
    logic             w_neq;
    logic             w_lt;
    logic             w_last;

`ifdef SIGNED_CMP_EN
    logic r_signed;
    assign w_signed = r_signed;
`else
    assign w_signed = 1'b0;
`endif

    // Flipping both sign bits on the leading slice turns a signed compare into an unsigned one.
    always_comb begin
        w_sa = r_a[WIDTH-1 -: DIGIT];
        w_sb = r_b[WIDTH-1 -: DIGIT];
        if (w_signed && (r_cnt == '0)) begin
            w_sa[DIGIT-1] = ~w_sa[DIGIT-1];
            w_sb[DIGIT-1] = ~w_sb[DIGIT-1];
        end
        w_neq  = (w_sa != w_sb);
        w_lt   = (w_sa < w_sb);
        w_last = (r_cnt == CW'(N - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (start) w_next = CMP;
            CMP:  if (w_neq || w_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_less    <= 1'b0;
            r_greater <= 1'b0;
            r_eq      <= 1'b0;
`ifdef SIGNED_CMP_EN
            r_signed  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a      <= a_in;
                        r_b      <= b_in;
                        r_cnt    <= '0;
`ifdef SIGNED_CMP_EN
                        r_signed <= signed_mode;
`endif
                    end
                end
                CMP: begin
                    r_a   <= r_a << DIGIT;
                    r_b   <= r_b << DIGIT;
                    r_cnt <= r_cnt + 1'b1;
                    // Result flags only move when a comparison completes, so they hold between done pulses.
                    if (w_neq) begin
                        r_less    <= w_lt;
                        r_greater <= ~w_lt;
                        r_eq      <= 1'b0;
                        r_done    <= 1'b1;
                    end else if (w_last) begin
                        r_less    <= 1'b0;
                        r_greater <= 1'b0;
                        r_eq      <= 1'b1;
                        r_done    <= 1'b1;
                    end
                end
                default: r_done <= 1'b0;
            endcase
        end
    end

    assign busy    = (r_state == CMP);
    assign done    = r_done;
    assign less    = r_less;
    assign greater = r_greater;
    assign eq      = r_eq;

endmodule

// File: tb/tb_comp_seq.sv
// Directed testbench for comp_seq with an expected-result queue; builds with or without SIGNED_CMP_EN.
module tb_comp_seq;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int N     = WIDTH / DIGIT;

    typedef struct {
        logic expLess;
        logic expGreater;
        logic expEq;
        int   expLat;
    } expT;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] aIn;
    logic [WIDTH-1:0] bIn;
    logic             busy;
    logic             done;
    logic             less;
    logic             greater;
    logic             eq;
`ifdef SIGNED_CMP_EN
    logic             signedMode;
`endif

    expT  scoreQ[$];
    int   checks;
    int   errors;
    int   cyc;
    logic holdLess;
    logic holdGreater;
    logic holdEq;

    comp_seq #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a_in       (aIn),
        .b_in       (bIn),
`ifdef SIGNED_CMP_EN
        .signed_mode(signedMode),
`endif
        .busy       (busy),
        .done       (done),
        .less       (less),
        .greater    (greater),
        .eq         (eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result: plain integer compare, latency from the first differing slice.
    function automatic expT model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sm);
        expT r;
        logic [WIDTH-1:0] sa;
        logic [WIDTH-1:0] sb;
        if (sm) begin
            r.expLess    = ($signed(a) < $signed(b));
            r.expGreater = ($signed(a) > $signed(b));
        end else begin
            r.expLess    = (a < b);
            r.expGreater = (a > b);
        end
        r.expEq  = (a == b);
        r.expLat = N;
        sa = a;
        sb = b;
        for (int i = 0; i < N; i++) begin
            if (sa[WIDTH-1 -: DIGIT] != sb[WIDTH-1 -: DIGIT]) begin
                r.expLat = i + 1;
                break;
            end
            sa = sa << DIGIT;
            sb = sb << DIGIT;
        end
        return r;
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
        cyc++;
    endtask

    // Drives one start pulse and queues its expected result; returns just after the accepting edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sm);
        logic effSm;
        aIn   = a;
        bIn   = b;
        start = 1'b1;
`ifdef SIGNED_CMP_EN
        signedMode = sm;
        effSm      = sm;
`else
        effSm      = 1'b0;
`endif
        scoreQ.push_back(model(a, b, effSm));
        @(negedge clk);
        cyc   = 0;
        start = 1'b0;
    endtask

    // Waits for done within a bounded cycle budget, checking busy and held flags on the way.
    task automatic checkOutput(input string tag);
        expT e;
        while (!done && cyc < N + 3) begin
            checkValue({tag, "_busy"}, 32'(busy), 32'd1);
            checkValue({tag, "_hold"}, {29'd0, less, greater, eq}, {29'd0, holdLess, holdGreater, holdEq});
            nextCycle();
        end
        checkValue({tag, "_done"}, 32'(done), 32'd1);
        if (scoreQ.size() == 0) begin
            errors++;
            $error("[TB] FAIL %s_queue: observed empty expected entry", tag);
            return;
        end
        e = scoreQ.pop_front();
        checkValue({tag, "_lat"}, 32'(cyc), 32'(e.expLat));
        checkValue({tag, "_flags"}, {29'd0, less, greater, eq}, {29'd0, e.expLess, e.expGreater, e.expEq});
        checkValue({tag, "_idle"}, 32'(busy), 32'd0);
        holdLess    = e.expLess;
        holdGreater = e.expGreater;
        holdEq      = e.expEq;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        holdLess    = 1'b0;
        holdGreater = 1'b0;
        holdEq      = 1'b0;
        rst         = 1'b1;
        start       = 1'b0;
        aIn         = '0;
        bIn         = '0;
`ifdef SIGNED_CMP_EN
        signedMode  = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checkValue("reset_outputs", {27'd0, busy, done, less, greater, eq}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(16'h1234, 16'h1234, 1'b0);
        checkOutput("equal");

        applyStimulus(16'h8000, 16'h7FFF, 1'b0);
        checkOutput("msb_unsigned");

`ifdef SIGNED_CMP_EN
        applyStimulus(16'h8000, 16'h7FFF, 1'b1);
        checkOutput("msb_signed");
        applyStimulus(16'hFFFE, 16'hFFFF, 1'b1);
        checkOutput("neg_signed");
`endif

        // Re-pulse start mid-compare with a different operand; neither may disturb the result.
        applyStimulus(16'h1235, 16'h1234, 1'b0);
        nextCycle();
        start = 1'b1;
        aIn   = 16'hFFFF;
        nextCycle();
        start = 1'b0;
        checkOutput("repulse");

        applyStimulus(16'h0F00, 16'h1000, 1'b0);
        checkOutput("first_slice_less");
        applyStimulus(16'h0001, 16'h0000, 1'b0);
        checkOutput("last_slice_greater");
        applyStimulus(16'hABCD, 16'hAB00, 1'b0);
        checkOutput("third_slice_greater");

        // Asynchronous reset mid-compare: outputs clear at once and no done follows.
        applyStimulus(16'h0000, 16'h00F0, 1'b0);
        nextCycle();
        #2 rst = 1'b1;
        #1 checkValue("async_reset", {27'd0, busy, done, less, greater, eq}, 32'd0);
        void'(scoreQ.pop_front());
        holdLess    = 1'b0;
        holdGreater = 1'b0;
        holdEq      = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            nextCycle();
            checkValue("no_done_after_abort", 32'(done), 32'd0);
        end
        applyStimulus(16'h0000, 16'h00F0, 1'b0);
        checkOutput("after_reset");

        // Start held high across a done: the second operation is accepted with no dead cycle.
        aIn   = 16'h1000;
        bIn   = 16'h2000;
        start = 1'b1;
        scoreQ.push_back(model(16'h1000, 16'h2000, 1'b0));
        @(negedge clk);
        cyc = 0;
        aIn = 16'hFFFF;
        bIn = 16'hFFFF;
        scoreQ.push_back(model(16'hFFFF, 16'hFFFF, 1'b0));
        checkOutput("b2b_first");
        nextCycle();
        cyc   = 0;
        start = 1'b0;
        checkValue("b2b_done_pulse", 32'(done), 32'd0);
        checkOutput("b2b_second");
        nextCycle();
        checkValue("final_done_low", 32'(done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
